// File: rtl/rs_station.sv
// Reservation station: holds dispatched ALU/branch/jump ops until both operands are ready,
// snoops the EX and LSB broadcast buses, and issues one ready entry per cycle as a registered packet.
module rs_station #(
   parameter int unsigned RS_SIZE   = 16,
   parameter int unsigned RS_ADD_W  = 4,
   parameter int unsigned INS_OP_W  = 5,
   parameter int unsigned REG_DAT_W = 32,
   parameter int unsigned ROB_ADD_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 iDC_En,
   input  logic [INS_OP_W-1:0]  iDC_Op,
   input  logic [REG_DAT_W-1:0] iDC_Pc,
   input  logic [REG_DAT_W-1:0] iDC_Imm,
   input  logic                 iDC_Rdy1,
   input  logic [REG_DAT_W-1:0] iDC_Vs1,
   input  logic [ROB_ADD_W-1:0] iDC_Qs1,
   input  logic                 iDC_Rdy2,
   input  logic [REG_DAT_W-1:0] iDC_Vs2,
   input  logic [ROB_ADD_W-1:0] iDC_Qs2,
   input  logic [ROB_ADD_W-1:0] iDC_Qd,
   output logic                 oDC_Full,
   input  logic                 iEX_En,
   input  logic [ROB_ADD_W-1:0] iEX_Qd,
   input  logic [REG_DAT_W-1:0] iEX_Vd,
   input  logic                 iLSB_En,
   input  logic [ROB_ADD_W-1:0] iLSB_Qd,
   input  logic [REG_DAT_W-1:0] iLSB_Vd,
   output logic                 oEX_En,
   output logic [INS_OP_W-1:0]  oEX_Op,
   output logic [REG_DAT_W-1:0] oEX_Pc,
   output logic [REG_DAT_W-1:0] oEX_Imm,
   output logic [REG_DAT_W-1:0] oEX_Vs1,
   output logic [REG_DAT_W-1:0] oEX_Vs2,
   output logic [ROB_ADD_W-1:0] oEX_Qd
);

   logic [RS_SIZE-1:0]   busy_q, rdy1_q, rdy2_q;
   logic [INS_OP_W-1:0]  op_q  [RS_SIZE];
   logic [REG_DAT_W-1:0] pc_q  [RS_SIZE];
   logic [REG_DAT_W-1:0] imm_q [RS_SIZE];
   logic [REG_DAT_W-1:0] v1_q  [RS_SIZE];
   logic [REG_DAT_W-1:0] v2_q  [RS_SIZE];
   logic [ROB_ADD_W-1:0] q1_q  [RS_SIZE];
   logic [ROB_ADD_W-1:0] q2_q  [RS_SIZE];
   logic [ROB_ADD_W-1:0] qd_q  [RS_SIZE];

   logic                 free_found, iss_found;
   logic [RS_ADD_W-1:0]  free_idx, iss_idx;
   logic                 dc_rdy1, dc_rdy2;
   logic [REG_DAT_W-1:0] dc_v1, dc_v2;

   assign oDC_Full = &busy_q;

   // Both selections use pre-edge state, so an entry freed by issue is not reused this cycle
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      iss_found  = 1'b0;
      iss_idx    = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!busy_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = RS_ADD_W'(i);
         end
         if (busy_q[i] && rdy1_q[i] && rdy2_q[i] && !iss_found) begin
            iss_found = 1'b1;
            iss_idx   = RS_ADD_W'(i);
         end
      end
   end

   // Same-cycle operand capture for the dispatching instruction; EX has priority over LSB
   always_comb begin
      dc_rdy1 = iDC_Rdy1;
      dc_v1   = iDC_Vs1;
      dc_rdy2 = iDC_Rdy2;
      dc_v2   = iDC_Vs2;
      if (!iDC_Rdy1) begin
         if (iEX_En && iEX_Qd == iDC_Qs1) begin
            dc_rdy1 = 1'b1;
            dc_v1   = iEX_Vd;
         end else if (iLSB_En && iLSB_Qd == iDC_Qs1) begin
            dc_rdy1 = 1'b1;
            dc_v1   = iLSB_Vd;
         end
      end
      if (!iDC_Rdy2) begin
         if (iEX_En && iEX_Qd == iDC_Qs2) begin
            dc_rdy2 = 1'b1;
            dc_v2   = iEX_Vd;
         end else if (iLSB_En && iLSB_Qd == iDC_Qs2) begin
            dc_rdy2 = 1'b1;
            dc_v2   = iLSB_Vd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         oEX_En  <= 1'b0;
         oEX_Op  <= '0;
         oEX_Pc  <= '0;
         oEX_Imm <= '0;
         oEX_Vs1 <= '0;
         oEX_Vs2 <= '0;
         oEX_Qd  <= '0;
      end else if (en) begin
         if (clr) begin
            busy_q  <= '0;
            oEX_En  <= 1'b0;
            oEX_Op  <= '0;
            oEX_Pc  <= '0;
            oEX_Imm <= '0;
            oEX_Vs1 <= '0;
            oEX_Vs2 <= '0;
            oEX_Qd  <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i] && !rdy1_q[i]) begin
                  if (iEX_En && iEX_Qd == q1_q[i]) begin
                     rdy1_q[i] <= 1'b1;
                     v1_q[i]   <= iEX_Vd;
                  end else if (iLSB_En && iLSB_Qd == q1_q[i]) begin
                     rdy1_q[i] <= 1'b1;
                     v1_q[i]   <= iLSB_Vd;
                  end
               end
               if (busy_q[i] && !rdy2_q[i]) begin
                  if (iEX_En && iEX_Qd == q2_q[i]) begin
                     rdy2_q[i] <= 1'b1;
                     v2_q[i]   <= iEX_Vd;
                  end else if (iLSB_En && iLSB_Qd == q2_q[i]) begin
                     rdy2_q[i] <= 1'b1;
                     v2_q[i]   <= iLSB_Vd;
                  end
               end
            end

            if (iss_found) begin
               busy_q[iss_idx] <= 1'b0;
               oEX_En  <= 1'b1;
               oEX_Op  <= op_q[iss_idx];
               oEX_Pc  <= pc_q[iss_idx];
               oEX_Imm <= imm_q[iss_idx];
               oEX_Vs1 <= v1_q[iss_idx];
               oEX_Vs2 <= v2_q[iss_idx];
               oEX_Qd  <= qd_q[iss_idx];
            end else begin
               oEX_En  <= 1'b0;
               oEX_Op  <= '0;
               oEX_Pc  <= '0;
               oEX_Imm <= '0;
               oEX_Vs1 <= '0;
               oEX_Vs2 <= '0;
               oEX_Qd  <= '0;
            end

            if (iDC_En && free_found) begin
               busy_q[free_idx] <= 1'b1;
               op_q[free_idx]   <= iDC_Op;
               pc_q[free_idx]   <= iDC_Pc;
               imm_q[free_idx]  <= iDC_Imm;
               rdy1_q[free_idx] <= dc_rdy1;
               v1_q[free_idx]   <= dc_v1;
               q1_q[free_idx]   <= iDC_Qs1;
               rdy2_q[free_idx] <= dc_rdy2;
               v2_q[free_idx]   <= dc_v2;
               q2_q[free_idx]   <= iDC_Qs2;
               qd_q[free_idx]   <= iDC_Qd;
            end
         end
      end
   end

endmodule
